// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
//   Shared encodings for the multi-cycle RV32I control path:
//     - RV32I major opcodes recognised by the control FSM
//     - ALUOp class codes handed to the ALU controller
//     - ALUSrcA / ALUSrcB / WBSel mux select encodings
//     - FSM state type and the instruction-class / control-word structs
//   No ports; imported by mc_opcode_decode and multicycle_control_fsm.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALUOp class codes
  localparam logic [1:0] ALUOP_ADD    = 2'b00;  // address / PC arithmetic
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;  // refine from funct7/funct3

  // ALU operand A select
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_RS1    = 2'b01;
  localparam logic [1:0] SRCA_OLD_PC = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Register-file write-back select
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_LINK   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_ILLEGAL  = 4'd11
  } mc_state_t;

  // One-hot instruction class; all-zero means the opcode is not supported.
  typedef struct packed {
    logic rtype;
    logic itype;
    logic load;
    logic store;
    logic branch;
    logic jal;
  } insn_class_t;

  // Per-state control word. The *_on_ready bits are qualified by mem_ready
  // at the output, everything else is a pure function of the state.
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write_on_ready;
    logic       pc_write;
    logic       pc_write_on_ready;
    logic       pc_write_cond;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire;
    logic       retire_on_ready;
    logic       trap;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage : riscv_ctrl_pkg

// File: rtl/mc_opcode_decode.sv
// ---------------------------------------------------------------------------
// mc_opcode_decode
//   Combinational opcode -> instruction-class one-hot used by the DECODE
//   dispatch of the multi-cycle control FSM. An unsupported opcode yields an
//   all-zero class vector.
//   Ports:
//     opcode   in  [6:0]         opcode field of the instruction register
//     cls      out insn_class_t  one-hot class (rtype/itype/load/store/branch/jal)
// ---------------------------------------------------------------------------
module mc_opcode_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output insn_class_t cls
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cls = '0;
    unique case (opcode)
      OPC_RTYPE:  cls.rtype  = 1'b1;
      OPC_ITYPE:  cls.itype  = 1'b1;
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      default:    cls        = '0;
    endcase
  end

endmodule : mc_opcode_decode

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Main control FSM of the multi-cycle RV32I core. Steps each instruction
//   through FETCH / DECODE / EXECUTE / MEM / WRITEBACK and drives the shared
//   ALU, memory port, register file and PC controls. Memory accesses stall on
//   mem_ready.
//
//   Build option:
//     MC_ILLEGAL_TRAP_EN defined   - unsupported opcode parks in ILLEGAL with
//                                    trap = 1 until reset.
//     MC_ILLEGAL_TRAP_EN undefined - unsupported opcode retires as a NOP and
//                                    trap stays 0.
//
//   Ports:
//     clk            in   core clock, rising edge
//     reset          in   synchronous active-low reset
//     opcode         in   [OPC_W-1:0] opcode from the instruction register
//     mem_ready      in   memory completes current read/write this cycle
//     ALUOp          out  [ALUOP_W-1:0] ALU class code
//     ALUSrcA        out  [1:0] 00 PC, 01 rs1, 10 old PC
//     ALUSrcB        out  [1:0] 00 rs2, 01 const 4, 10 immediate
//     MemRead        out  memory read request
//     MemWrite       out  memory write request
//     IorD           out  0 PC address, 1 ALUOut address
//     IRWrite        out  latch fetched word into IR
//     PCWrite        out  unconditional PC update
//     PCWriteCond    out  PC update when the branch flag is set
//     PCSrc          out  0 ALU result, 1 ALUOut
//     RegWrite       out  register file write enable
//     WBSel          out  [1:0] 00 ALUOut, 01 MDR, 10 PC link
//     instr_retired  out  pulse in the final state of each instruction
//     trap           out  illegal-opcode flag
// ---------------------------------------------------------------------------
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OPC_W   = 7,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic [1:0]         WBSel,
  output logic               instr_retired,
  output logic               trap
);

  mc_state_t   state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  ctrl_t       ctrl_out;
  insn_class_t cls;

  mc_opcode_decode u_opcode_decode (
    .opcode (opcode),
    .cls    (cls)
  );

  // Moore control word for a given state.
  function automatic ctrl_t decode_ctrl(input mc_state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      ST_FETCH: begin
        c.mem_read          = 1'b1;
        c.alu_src_a         = SRCA_PC;
        c.alu_src_b         = SRCB_FOUR;
        c.alu_op            = ALUOP_ADD;
        c.ir_write_on_ready = 1'b1;
        c.pc_write_on_ready = 1'b1;
      end
      ST_DECODE: begin
        // Precompute the branch / jump target into ALUOut.
        c.alu_src_a = SRCA_OLD_PC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write       = 1'b1;
        c.iord            = 1'b1;
        c.retire_on_ready = 1'b1;
      end
      ST_WB_ALU: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_ALUOUT;
        c.retire    = 1'b1;
      end
      ST_WB_MEM: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_MDR;
        c.retire    = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = SRCA_RS1;
        c.alu_src_b     = SRCB_RS2;
        c.alu_op        = ALUOP_BRANCH;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 1'b1;
        c.retire        = 1'b1;
      end
      ST_JAL: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_LINK;
        c.pc_write  = 1'b1;
        c.pc_src    = 1'b1;
        c.retire    = 1'b1;
      end
      ST_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        c.trap   = 1'b1;
`else
        c.retire = 1'b1;
`endif
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Next-state logic; the control word is then decoded from the next state
  // so the registered outputs line up with state_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if      (cls.rtype)              state_d = ST_EXEC_R;
        else if (cls.itype)              state_d = ST_EXEC_I;
        else if (cls.load || cls.store)  state_d = ST_MEM_ADDR;
        else if (cls.branch)             state_d = ST_BRANCH;
        else if (cls.jal)                state_d = ST_JAL;
        else                             state_d = ST_ILLEGAL;
      end
      ST_EXEC_R,
      ST_EXEC_I:   state_d = ST_WB_ALU;
      ST_MEM_ADDR: state_d = cls.store ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_WB_ALU,
      ST_WB_MEM,
      ST_BRANCH,
      ST_JAL:      state_d = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_ILLEGAL:  state_d = ST_ILLEGAL;
`else
      ST_ILLEGAL:  state_d = ST_FETCH;
`endif
      default:     state_d = ST_FETCH;
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q <= ST_FETCH;
      ctrl_q  <= decode_ctrl(ST_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // While reset is held low every control goes quiet, even though the state
  // register already sits in FETCH; this also aborts a mid-flight write.
  assign ctrl_out = reset ? ctrl_q : CTRL_IDLE;

  assign ALUOp         = ctrl_out.alu_op;
  assign ALUSrcA       = ctrl_out.alu_src_a;
  assign ALUSrcB       = ctrl_out.alu_src_b;
  assign MemRead       = ctrl_out.mem_read;
  assign MemWrite      = ctrl_out.mem_write;
  assign IorD          = ctrl_out.iord;
  assign IRWrite       = ctrl_out.ir_write_on_ready & mem_ready;
  assign PCWrite       = ctrl_out.pc_write | (ctrl_out.pc_write_on_ready & mem_ready);
  assign PCWriteCond   = ctrl_out.pc_write_cond;
  assign PCSrc         = ctrl_out.pc_src;
  assign RegWrite      = ctrl_out.reg_write;
  assign WBSel         = ctrl_out.wb_sel;
  assign instr_retired = ctrl_out.retire | (ctrl_out.retire_on_ready & mem_ready);
  assign trap          = ctrl_out.trap;

endmodule : multicycle_control_fsm

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed bench for multicycle_control_fsm. Instructions are expanded into
//   a per-cycle schedule of (inputs, expected outputs) from the step rules of
//   each instruction class; a single loop applies every cycle and compares.
//   Literal latency / pulse-count expectations pin the schedule itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam int TRAP_MODE = 1;
`else
  localparam int TRAP_MODE = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, WBSel;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
  logic       PCSrc, RegWrite, instr_retired, trap;

  multicycle_control_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .ALUOp         (ALUOp),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .IorD          (IorD),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .PCWriteCond   (PCWriteCond),
    .PCSrc         (PCSrc),
    .RegWrite      (RegWrite),
    .WBSel         (WBSel),
    .instr_retired (instr_retired),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retired;
    logic       trap;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic [6:0] opc;
    logic       rdy;
    exp_t       e;
    int         lat;    // expected instruction latency, 0 = not measured
    bit         first;  // first cycle of an instruction
  } cyc_t;

  cyc_t sched[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic rst_n, input logic [6:0] opc, input logic rdy,
                               input exp_t e, input int lat, input bit first);
    cyc_t c;
    c.rst_n = rst_n;
    c.opc   = opc;
    c.rdy   = rdy;
    c.e     = e;
    c.lat   = lat;
    c.first = first;
    sched.push_back(c);
  endfunction

  // Reset held low for n cycles: every output must read zero.
  function automatic void add_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 7'd0, 1'b1, exp_t'(0), 0, 1'b1);
  endfunction

  // Fetch with fetch_waits stalled cycles, then decode.
  function automatic void add_front(input logic [6:0] opc, input int fetch_waits, input int lat);
    exp_t e;
    for (int i = 0; i <= fetch_waits; i++) begin
      e          = '0;
      e.mem_read = 1'b1;
      e.src_b    = 2'b01;
      e.ir_write = (i == fetch_waits);
      e.pc_write = (i == fetch_waits);
      push(1'b1, opc, (i == fetch_waits), e, lat, (i == 0));
    end
    e       = '0;
    e.src_a = 2'b10;
    e.src_b = 2'b10;
    push(1'b1, opc, 1'b0, e, lat, 1'b0);  // mem_ready low: decode must not care
  endfunction

  function automatic void add_instr(input logic [6:0] opc, input int fetch_waits,
                                    input int mem_waits, input int lat);
    exp_t e;
    add_front(opc, fetch_waits, lat);
    case (opc)
      OP_R, OP_I: begin
        e        = '0;
        e.src_a  = 2'b01;
        e.src_b  = (opc == OP_R) ? 2'b00 : 2'b10;
        e.alu_op = 2'b10;
        push(1'b1, opc, 1'b1, e, lat, 1'b0);
        e           = '0;
        e.reg_write = 1'b1;
        e.wb_sel    = 2'b00;
        e.retired   = 1'b1;
        push(1'b1, opc, 1'b1, e, lat, 1'b0);
      end
      OP_LD, OP_ST: begin
        e       = '0;
        e.src_a = 2'b01;
        e.src_b = 2'b10;
        push(1'b1, opc, 1'b0, e, lat, 1'b0);
        for (int i = 0; i <= mem_waits; i++) begin
          e      = '0;
          e.iord = 1'b1;
          if (opc == OP_ST) begin
            e.mem_write = 1'b1;
            e.retired   = (i == mem_waits);
          end else begin
            e.mem_read = 1'b1;
          end
          push(1'b1, opc, (i == mem_waits), e, lat, 1'b0);
        end
        if (opc == OP_LD) begin
          e           = '0;
          e.reg_write = 1'b1;
          e.wb_sel    = 2'b01;
          e.retired   = 1'b1;
          push(1'b1, opc, 1'b1, e, lat, 1'b0);
        end
      end
      OP_BR: begin
        e               = '0;
        e.src_a         = 2'b01;
        e.src_b         = 2'b00;
        e.alu_op        = 2'b01;
        e.pc_write_cond = 1'b1;
        e.pc_src        = 1'b1;
        e.retired       = 1'b1;
        push(1'b1, opc, 1'b1, e, lat, 1'b0);
      end
      OP_JAL: begin
        e           = '0;
        e.reg_write = 1'b1;
        e.wb_sel    = 2'b10;
        e.pc_write  = 1'b1;
        e.pc_src    = 1'b1;
        e.retired   = 1'b1;
        push(1'b1, opc, 1'b0, e, lat, 1'b0);
      end
      default: begin
        if (TRAP_MODE != 0) begin
          // Sticky: trap held, no enables, for a dozen cycles of varied ready.
          for (int i = 0; i < 12; i++) begin
            e      = '0;
            e.trap = 1'b1;
            push(1'b1, opc, i[0], e, lat, 1'b0);
          end
        end else begin
          e         = '0;
          e.retired = 1'b1;
          push(1'b1, opc, 1'b1, e, lat, 1'b0);
        end
      end
    endcase
  endfunction

  // R-type aborted by reset while in its execute step.
  function automatic void add_aborted_r();
    add_front(OP_R, 0, 0);
    push(1'b0, OP_R, 1'b1, exp_t'(0), 0, 1'b0);
  endfunction

  initial begin
    exp_t act;
    int   cyc       = 0;
    int   start     = 0;
    int   cur_lat   = 0;
    int   retires   = 0;
    int   mw_starts = 0;
    int   ir_loads  = 0;
    logic mw_prev   = 1'b0;

    reset     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b0;

    add_reset(3);
    add_instr(OP_R,   0, 0, 4);
    add_instr(OP_LD,  0, 2, 7);
    add_instr(OP_ST,  0, 1, 5);
    add_instr(OP_BR,  0, 0, 3);
    add_instr(OP_I,   1, 0, 5);
    add_instr(OP_JAL, 2, 0, 5);
    add_instr(OP_LD,  0, 0, 5);
    add_instr(OP_ST,  0, 0, 4);
    add_aborted_r();
    add_instr(OP_R,   0, 0, 4);
    add_instr(OP_BAD, 0, 0, (TRAP_MODE != 0) ? 0 : 3);
    add_reset(2);
    add_instr(OP_JAL, 0, 0, 3);

    while (sched.size() > 0) begin
      cyc_t c;
      c         = sched.pop_front();
      reset     = c.rst_n;
      opcode    = c.opc;
      mem_ready = c.rdy;
      if (c.first) begin
        start   = cyc;
        cur_lat = c.lat;
      end
      @(negedge clk);
      act = {ALUOp, ALUSrcA, ALUSrcB, MemRead, MemWrite, IorD, IRWrite, PCWrite,
             PCWriteCond, PCSrc, RegWrite, WBSel, instr_retired, trap};
      check($sformatf("cycle %0d outputs", cyc), {14'd0, act}, {14'd0, c.e});
      if (instr_retired) begin
        retires++;
        if (cur_lat != 0) begin
          check($sformatf("cycle %0d latency", cyc), cyc - start + 1, cur_lat);
          cur_lat = 0;
        end
      end
      if (MemWrite && !mw_prev) mw_starts++;
      mw_prev = MemWrite;
      if (IRWrite) ir_loads++;
      @(posedge clk);
      #1;
      cyc++;
    end

    check("retired instructions", retires, (TRAP_MODE != 0) ? 10 : 11);
    check("store write requests", mw_starts, 2);
    check("IR loads", ir_loads, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_multicycle_control_fsm
